// File: rtl/ariane_pkg.sv
// Shared pipeline types: the scoreboard entry plus the decode-queue slot and FSM state.
// Used by decode_issue_queue and decode_q_fifo.
package ariane_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } decode_q_entry_t;

  typedef enum logic {
    DQ_IDLE,
    DQ_BRANCH_PENDING
  } decode_q_state_e;

endpackage

// File: rtl/decode_q_fifo.sv
// Generic circular FIFO with pointer/count bookkeeping and a synchronous flush.
// Callers guarantee no push when full and no pop when empty.
module decode_q_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = decode_q_entry_t
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  T              r_mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by r_count alone, which
  // keeps the array free of a reset tree.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/decode_issue_queue.sv
// Decode-to-issue decoupling queue with branch hold-back and flush.
// Optional macro DECODE_QUEUE_BYPASS_EN presents an incoming entry combinationally when empty.
module decode_issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_instr_valid_o,
  output logic              is_ctrl_flow_o,
  input  logic              issue_instr_ack_i,
  input  logic              resolve_branch_i,
  output logic              empty_o
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  decode_q_state_e r_state;
  decode_q_entry_t w_in;
  decode_q_entry_t w_head;
  decode_q_entry_t w_issue;
  logic [CW-1:0]   w_count;
  logic            w_bypass;
  logic            w_present;
  logic            w_gated;
  logic            w_issue_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_fifo_pop;

  assign w_in = '{sbe: decoded_instr_i, is_ctrl_flow: is_ctrl_flow_i};

  // Full blocks push even on a same-cycle pop, so ack never depends on issue ack.
  assign decoded_instr_ack_o = decoded_instr_valid_i & (w_count != FULL) & !flush_i;

`ifdef DECODE_QUEUE_BYPASS_EN
  assign w_bypass = (w_count == '0) & decoded_instr_valid_i & !flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_issue       = w_bypass ? w_in : w_head;
  assign w_present     = w_bypass | (w_count != '0);
  assign w_gated       = (r_state == DQ_BRANCH_PENDING) & w_issue.is_ctrl_flow;
  assign w_issue_valid = w_present & !w_gated & !flush_i;
  assign w_pop         = issue_instr_ack_i & w_issue_valid;

  // A bypassed entry consumed in the same cycle never touches the storage.
  assign w_push     = decoded_instr_ack_o & !(w_bypass & w_pop);
  assign w_fifo_pop = w_pop & !w_bypass;

  decode_q_fifo #(
    .DEPTH (DEPTH),
    .T     (decode_q_entry_t)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_fifo_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= DQ_IDLE;
    end else if (flush_i) begin
      r_state <= DQ_IDLE;
    end else begin
      case (r_state)
        DQ_IDLE:
          if (w_pop && w_issue.is_ctrl_flow && !resolve_branch_i) r_state <= DQ_BRANCH_PENDING;
        DQ_BRANCH_PENDING:
          if (resolve_branch_i) r_state <= DQ_IDLE;
        default: r_state <= DQ_IDLE;
      endcase
    end
  end

  assign issue_instr_o       = w_issue.sbe;
  assign issue_instr_valid_o = w_issue_valid;
  assign is_ctrl_flow_o      = w_present & w_issue.is_ctrl_flow;
  assign empty_o             = (w_count == '0);

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus a randomized
// run against a queue-based reference model; honours DECODE_QUEUE_BYPASS_EN.
module tb_decode_issue_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  scoreboard_entry_t sbe_i;
  logic              valid_i;
  logic              cf_i;
  logic              ack_o;
  scoreboard_entry_t issue_o;
  logic              issue_valid_o;
  logic              cf_o;
  logic              iack_i;
  logic              resolve_i;
  logic              empty_o;

  int errors = 0;
  int checks = 0;

  decode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush_i),
    .decoded_instr_i       (sbe_i),
    .decoded_instr_valid_i (valid_i),
    .is_ctrl_flow_i        (cf_i),
    .decoded_instr_ack_o   (ack_o),
    .issue_instr_o         (issue_o),
    .issue_instr_valid_o   (issue_valid_o),
    .is_ctrl_flow_o        (cf_o),
    .issue_instr_ack_i     (iack_i),
    .resolve_branch_i      (resolve_i),
    .empty_o               (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic cf, input logic [63:0] pc,
                       input logic iack, input logic res, input logic fl);
    valid_i   = v;
    cf_i      = cf;
    sbe_i     = '0;
    sbe_i.pc  = pc;
    iack_i    = iack;
    resolve_i = res;
    flush_i   = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", issue_valid_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_o); end
    checks++; if (cf_o !== 1'b0) begin errors++; $display("FAIL reset_cf: got %b want 0", cf_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_o); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (ack_o !== (i < DEPTH)) begin errors++; $display("FAIL fill_ack[%0d]: got %b want %b", i, ack_o, (i < DEPTH)); end
      next_cycle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h8000_0000 + 64'(4 * i)) begin
        errors++; $display("FAIL drain[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, issue_valid_o, issue_o.pc, 64'h8000_0000 + 64'(4 * i));
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (empty_o !== 1'b1 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got empty=%b valid=%b want 1/0", empty_o, issue_valid_o); end
    next_cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 64'h8000_0000, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10, 1'b0, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h8000_0000 + 64'(4 * (i - 1))) begin
        errors++; $display("FAIL wrap[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i - 1, issue_valid_o, issue_o.pc, 64'h8000_0000 + 64'(4 * (i - 1)));
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty_o); end
    next_cycle();
  endtask

  task automatic test_branch_hold();
    do_reset();
    drive(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 1'b0, 64'h104, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 1'b1, 64'h108, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h100 || cf_o !== 1'b1) begin errors++; $display("FAIL hold_popA: got valid=%b pc=%h cf=%b want 1/100/1", issue_valid_o, issue_o.pc, cf_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h104 || cf_o !== 1'b0) begin errors++; $display("FAIL hold_popB: got valid=%b pc=%h cf=%b want 1/104/0", issue_valid_o, issue_o.pc, cf_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b0 || cf_o !== 1'b1 || empty_o !== 1'b0) begin errors++; $display("FAIL hold_C_blocked: got valid=%b cf=%b empty=%b want 0/1/0", issue_valid_o, cf_o, empty_o); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL hold_resolve_cycle: got valid=%b want 0", issue_valid_o); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h108) begin errors++; $display("FAIL hold_C_release: got valid=%b pc=%h want 1/108", issue_valid_o, issue_o.pc); end
    next_cycle();
  endtask

  task automatic test_resolve_same_cycle();
    do_reset();
    drive(1'b1, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 1'b1, 64'h204, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h200) begin errors++; $display("FAIL same_res_pop: got valid=%b pc=%h want 1/200", issue_valid_o, issue_o.pc); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h204) begin errors++; $display("FAIL same_res_next: got valid=%b pc=%h want 1/204", issue_valid_o, issue_o.pc); end
    next_cycle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, (i == 0), 64'h300 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 64'h310, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (ack_o !== 1'b0 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL flush_same: got ack=%b valid=%b want 0/0", ack_o, issue_valid_o); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (empty_o !== 1'b1 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL flush_next: got empty=%b valid=%b want 1/0", empty_o, issue_valid_o); end
    next_cycle();
    drive(1'b1, 1'b1, 64'h320, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h320) begin errors++; $display("FAIL flush_idle: got valid=%b pc=%h want 1/320", issue_valid_o, issue_o.pc); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0, 64'h400, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 1'b0, 64'h404, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (issue_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_before: got valid=%b want 1", issue_valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (issue_valid_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_after: got valid=%b empty=%b want 0/1", issue_valid_o, empty_o); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_latency();
    do_reset();
    drive(1'b1, 1'b0, 64'h500, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef DECODE_QUEUE_BYPASS_EN
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h500 || ack_o !== 1'b1) begin errors++; $display("FAIL bypass_issue: got valid=%b pc=%h ack=%b want 1/500/1", issue_valid_o, issue_o.pc, ack_o); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (empty_o !== 1'b1 || issue_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_count: got empty=%b valid=%b want 1/0", empty_o, issue_valid_o); end
`else
    checks++; if (issue_valid_o !== 1'b0 || ack_o !== 1'b1) begin errors++; $display("FAIL lat_same: got valid=%b ack=%b want 0/1", issue_valid_o, ack_o); end
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue_valid_o !== 1'b1 || issue_o.pc !== 64'h500) begin errors++; $display("FAIL lat_next: got valid=%b pc=%h want 1/500", issue_valid_o, issue_o.pc); end
`endif
    next_cycle();
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        cf;
  } model_t;

  task automatic test_random();
    model_t      mq[$];
    model_t      item;
    bit          pend;
    bit          v, cf, iack, res, fl, byp, hv, hcf, e_ack, e_valid, popped;
    logic [63:0] pc, hpc;
    do_reset();
    pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v    = ($urandom_range(9) < 7);
      cf   = ($urandom_range(9) < 3);
      iack = ($urandom_range(9) < 6);
      res  = ($urandom_range(9) < 3);
      fl   = ($urandom_range(19) == 0);
      pc   = {32'h0, $urandom};
      drive(v, cf, pc, iack, res, fl);
      @(negedge clk);
      e_ack = v && (mq.size() < DEPTH) && !fl;
      byp   = 0;
`ifdef DECODE_QUEUE_BYPASS_EN
      byp = (mq.size() == 0) && v && !fl;
`endif
      if (byp) begin hv = 1; hpc = pc; hcf = cf; end
      else if (mq.size() > 0) begin hv = 1; hpc = mq[0].pc; hcf = mq[0].cf; end
      else begin hv = 0; hpc = '0; hcf = 0; end
      e_valid = hv && !fl && !(pend && hcf);
      checks++; if (ack_o !== e_ack) begin errors++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, ack_o, e_ack); end
      checks++; if (issue_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, issue_valid_o, e_valid); end
      checks++; if (empty_o !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d: got %b want %b", cyc, empty_o, (mq.size() == 0)); end
      if (e_valid) begin
        checks++;
        if (issue_o.pc !== hpc || cf_o !== hcf) begin errors++; $display("FAIL rnd_head@%0d: got pc=%h cf=%b want pc=%h cf=%b", cyc, issue_o.pc, cf_o, hpc, hcf); end
      end
      if (fl) begin
        mq.delete();
        pend = 0;
      end else begin
        popped = iack && e_valid;
        if (popped && !byp) void'(mq.pop_front());
        pend = pend ? !res : (popped && hcf && !res);
        if (e_ack && !(byp && popped)) begin
          item.pc = pc;
          item.cf = cf;
          mq.push_back(item);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_branch_hold();
    test_resolve_same_cycle();
    test_flush();
    test_reset_mid();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
